// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: bus structs, the fetch output bundle and the FSM state enum.
// FETCH_MISALIGN_EN (optional) enables misaligned-PC exception reporting in fetch.
package fetch_pkg;

  typedef logic [63:0] addr_t;

  localparam addr_t PC_RESET_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    addr_t       pc;
    logic [31:0] raw_instr;
  } instr_t;

  typedef struct packed {
    logic   valid;
    instr_t instr;
    logic   exc_misalign;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic misaligned(addr_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_select.sv
// Next-PC mux for the fetch stage: redirect beats sequential advance beats hold.
// Kept separate so a branch predictor can slot in here later.
module pc_select
  import fetch_pkg::*;
(
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  input  logic  advance,
  input  addr_t pc_q,
  output addr_t pc_next
);

  always_comb begin
    pc_next = pc_q;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (advance) begin
      pc_next = pc_q + 64'd4;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one ibus request at a time, registers the result for decode.
// Optional build macro FETCH_MISALIGN_EN turns misaligned PCs into an exc_misalign record instead of a fetch.
module fetch
  import fetch_pkg::*;
#(
  parameter addr_t PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output fetch_data_t dataF,
  input  logic        stall,
  input  logic        redirect_valid,
  input  addr_t       redirect_pc
);

  fetch_state_t state_q, state_nxt, state_d;
  addr_t        pc_q, pc_d;
  addr_t        req_addr_q, req_addr_d;
  fetch_data_t  data_q, data_d;
  logic         consume, slot_free, advance;
  logic         addr_ok_unused;

  assign addr_ok_unused = iresp.addr_ok;
  assign consume        = data_q.valid & ~stall;
  assign slot_free      = ~data_q.valid | consume;

  pc_select u_pc_select (
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc_q           (pc_q),
    .pc_next        (pc_d)
  );

  always_comb begin
    state_nxt = state_q;
    data_d    = data_q;
    advance   = 1'b0;
    if (consume) begin
      data_d.valid = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          state_nxt = REQ;
        end else if (slot_free) begin
`ifdef FETCH_MISALIGN_EN
          if (misaligned(pc_q)) begin
            data_d.valid           = 1'b1;
            data_d.instr.pc        = pc_q;
            data_d.instr.raw_instr = '0;
            data_d.exc_misalign    = 1'b1;
          end else begin
            state_nxt = REQ;
          end
`else
          state_nxt = REQ;
`endif
        end
      end
      REQ: begin
        if (redirect_valid) begin
          // A response arriving with the redirect is stale; the bus is free again.
          state_nxt = iresp.data_ok ? REQ : DISCARD;
        end else if (iresp.data_ok) begin
          data_d.valid           = 1'b1;
          data_d.instr.pc        = pc_q;
          data_d.instr.raw_instr = iresp.data;
          data_d.exc_misalign    = 1'b0;
          advance                = 1'b1;
          state_nxt              = slot_free ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (iresp.data_ok) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      data_d.valid = 1'b0;
    end
  end

  // Final state and request address depend on the selected next PC.
  always_comb begin
    state_d = state_nxt;
`ifdef FETCH_MISALIGN_EN
    if (state_nxt == REQ && misaligned(pc_d)) begin
      state_d = IDLE;
    end
`endif
    req_addr_d = req_addr_q;
    if (state_d == REQ) begin
      req_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      data_q     <= data_d;
    end
  end

  assign ireq.valid = (state_q == REQ) || (state_q == DISCARD);
  assign ireq.addr  = req_addr_q;

  always_comb begin
    dataF = data_q;
`ifndef FETCH_MISALIGN_EN
    dataF.exc_misalign = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus a randomized run against a PC-stream model.
module tb_fetch;
  import fetch_pkg::*;

  localparam addr_t PC0 = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  fetch_data_t dataF;
  logic        stall;
  logic        redirect_valid;
  addr_t       redirect_pc;

  int checks = 0;
  int passes = 0;

  bit    mem_busy  = 1'b0;
  addr_t mem_addr  = '0;
  int    mem_wait  = 0;
  int    lat_min   = 1;
  int    lat_max   = 1;
  bit    mem_fixed = 1'b0;

  always #5 clk = ~clk;

  fetch #(.PC_RESET(PC0)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .dataF          (dataF),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_word(addr_t a);
    return a[31:0] * 32'd3 + 32'h0000_0013;
  endfunction

  // Memory: accepts one request, answers after a random latency, never while decode holds a stalled instruction.
  task automatic mem_drive();
    iresp = '0;
    iresp.addr_ok = 1'($urandom_range(1, 0));
    if (!reset) begin
      mem_busy = 1'b0;
      return;
    end
    if (!mem_busy && ireq.valid) begin
      mem_busy = 1'b1;
      mem_addr = ireq.addr;
      mem_wait = int'($urandom_range(lat_max, lat_min));
    end
    if (mem_busy) begin
      if (mem_wait == 0) begin
        if (!(dataF.valid && stall)) begin
          iresp.data_ok = 1'b1;
          iresp.data    = mem_fixed ? 32'h0000_0013 : mem_word(mem_addr);
          mem_busy      = 1'b0;
        end
      end else begin
        mem_wait--;
      end
    end
  endtask

  task automatic cycle();
    mem_drive();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    cycle();
    cycle();
    checks++; if (ireq.valid !== 1'b0) $display("FAIL reset_ireq_valid: got %b want 0", ireq.valid); else passes++;
    checks++; if (dataF !== '0) $display("FAIL reset_dataF: got %h want 0", dataF); else passes++;
    checks++; if (ireq.addr !== PC0) $display("FAIL reset_req_addr: got %h want %h", ireq.addr, PC0); else passes++;
    reset = 1'b1;
    cycle();
    checks++; if (ireq.valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", ireq.valid); else passes++;
    checks++; if (ireq.addr !== PC0) $display("FAIL first_req_addr: got %h want %h", ireq.addr, PC0); else passes++;
  endtask

  task automatic test_stream();
    int n;
    mem_fixed = 1'b1;
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin cycle(); n++; end while (!dataF.valid && n < 10);
      checks++; if (dataF.valid !== 1'b1) $display("FAIL stream_valid%0d: got %b want 1", k, dataF.valid); else passes++;
      checks++; if (dataF.instr.pc !== PC0 + 64'(4 * k)) $display("FAIL stream_pc%0d: got %h want %h", k, dataF.instr.pc, PC0 + 64'(4 * k)); else passes++;
      checks++; if (dataF.instr.raw_instr !== 32'h13) $display("FAIL stream_raw%0d: got %h want 00000013", k, dataF.instr.raw_instr); else passes++;
      checks++; if (n !== ((k == 0) ? 3 : 2)) $display("FAIL stream_latency%0d: got %0d want %0d", k, n, (k == 0) ? 3 : 2); else passes++;
      checks++; if (ireq.valid !== 1'b1 || ireq.addr !== PC0 + 64'(4 * (k + 1))) $display("FAIL stream_next_req%0d: got %b/%h want 1/%h", k, ireq.valid, ireq.addr, PC0 + 64'(4 * (k + 1))); else passes++;
    end
  endtask

  task automatic test_stall();
    fetch_data_t snap;
    int n;
    snap  = dataF;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (dataF !== snap) $display("FAIL stall_hold%0d: got %h want %h", i, dataF, snap); else passes++;
      checks++; if (ireq.addr !== snap.instr.pc + 64'd4) $display("FAIL stall_req_addr%0d: got %h want %h", i, ireq.addr, snap.instr.pc + 64'd4); else passes++;
    end
    stall = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!dataF.valid && n < 10);
    checks++; if (dataF.valid !== 1'b1 || dataF.instr.pc !== snap.instr.pc + 64'd4) $display("FAIL stall_release_pc: got %b/%h want 1/%h", dataF.valid, dataF.instr.pc, snap.instr.pc + 64'd4); else passes++;
    mem_fixed = 1'b0;
  endtask

  task automatic test_redirect_wait();
    addr_t old_addr;
    bit    seen_req;
    int    n;
    lat_min = 3; lat_max = 3;
    do_reset();
    n = 0;
    do begin cycle(); n++; end while (!ireq.valid && n < 5);
    old_addr = ireq.addr;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (dataF.valid !== 1'b0) $display("FAIL redir_wait_flush: got %b want 0", dataF.valid); else passes++;
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== old_addr) $display("FAIL redir_wait_addr_stable: got %b/%h want 1/%h", ireq.valid, ireq.addr, old_addr); else passes++;
    seen_req = 1'b0;
    n = 0;
    do begin
      cycle(); n++;
      if (ireq.valid && ireq.addr == 64'h8000_0100) seen_req = 1'b1;
    end while (!dataF.valid && n < 20);
    checks++; if (seen_req !== 1'b1) $display("FAIL redir_wait_req_seen: got %b want 1", seen_req); else passes++;
    checks++; if (dataF.valid !== 1'b1 || dataF.instr.pc !== 64'h8000_0100) $display("FAIL redir_wait_pc: got %b/%h want 1/80000100", dataF.valid, dataF.instr.pc); else passes++;
    checks++; if (dataF.instr.raw_instr !== mem_word(64'h8000_0100)) $display("FAIL redir_wait_raw: got %h want %h", dataF.instr.raw_instr, mem_word(64'h8000_0100)); else passes++;
  endtask

  task automatic test_redirect_same();
    int n;
    lat_min = 1; lat_max = 1;
    do_reset();
    n = 0;
    do begin cycle(); n++; end while (!ireq.valid && n < 5);
    cycle();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (dataF.valid !== 1'b0) $display("FAIL redir_same_no_stale: got %b want 0", dataF.valid); else passes++;
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0200) $display("FAIL redir_same_req: got %b/%h want 1/80000200", ireq.valid, ireq.addr); else passes++;
    n = 0;
    do begin cycle(); n++; end while (!dataF.valid && n < 10);
    checks++; if (dataF.valid !== 1'b1 || dataF.instr.pc !== 64'h8000_0200) $display("FAIL redir_same_pc: got %b/%h want 1/80000200", dataF.valid, dataF.instr.pc); else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    lat_min = 1; lat_max = 1;
    do_reset();
    n = 0;
    do begin cycle(); n++; end while (!dataF.valid && n < 10);
    reset = 1'b0;
    cycle();
    checks++; if (ireq.valid !== 1'b0 || dataF.valid !== 1'b0) $display("FAIL reset_mid_clear: got %b/%b want 0/0", ireq.valid, dataF.valid); else passes++;
    reset = 1'b1;
    cycle();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== PC0) $display("FAIL reset_mid_restart: got %b/%h want 1/%h", ireq.valid, ireq.addr, PC0); else passes++;
    n = 0;
    do begin cycle(); n++; end while (!dataF.valid && n < 10);
    checks++; if (dataF.valid !== 1'b1 || dataF.instr.pc !== PC0) $display("FAIL reset_mid_pc: got %b/%h want 1/%h", dataF.valid, dataF.instr.pc, PC0); else passes++;
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    bit          bus_used;
    bit          got;
    fetch_data_t first;
    lat_min = 1; lat_max = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    cycle();
    redirect_valid = 1'b0;
    bus_used = 1'b0; got = 1'b0; first = '0;
    for (int i = 0; i < 6; i++) begin
      if (ireq.valid) bus_used = 1'b1;
      if (dataF.valid && !got) begin got = 1'b1; first = dataF; end
      cycle();
    end
    checks++; if (bus_used !== 1'b0) $display("FAIL misalign_no_bus: got %b want 0", bus_used); else passes++;
    checks++; if (got !== 1'b1 || first.exc_misalign !== 1'b1 || first.instr.pc !== 64'h8000_0102 || first.instr.raw_instr !== 32'h0) $display("FAIL misalign_record: got %b/%b/%h/%h want 1/1/80000102/0", got, first.exc_misalign, first.instr.pc, first.instr.raw_instr); else passes++;
  endtask
`endif

  task automatic test_random();
    addr_t       exp_pc;
    addr_t       target;
    fetch_data_t snap;
    bit          chk_hold, chk_flush, redir;
    int          consumed;
    lat_min = 0; lat_max = 3;
    do_reset();
    exp_pc = PC0; chk_hold = 1'b0; chk_flush = 1'b0; consumed = 0; snap = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (chk_hold) begin
        checks++; if (dataF !== snap) $display("FAIL rand_hold@%0d: got %h want %h", cyc, dataF, snap); else passes++;
      end
      if (chk_flush) begin
        checks++; if (dataF.valid !== 1'b0) $display("FAIL rand_flush@%0d: got %b want 0", cyc, dataF.valid); else passes++;
      end
      if (mem_busy) begin
        checks++; if (ireq.valid !== 1'b1 || ireq.addr !== mem_addr) $display("FAIL rand_req_stable@%0d: got %b/%h want 1/%h", cyc, ireq.valid, ireq.addr, mem_addr); else passes++;
      end
      stall  = ($urandom_range(99) < 30);
      redir  = ($urandom_range(99) < 5);
      target = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : ({$urandom(), $urandom()} & ~64'h3);
      if (dataF.valid && !stall) begin
        checks++;
        if (dataF.instr.pc !== exp_pc || dataF.instr.raw_instr !== mem_word(exp_pc) || dataF.exc_misalign !== 1'b0)
          $display("FAIL rand_instr@%0d: got %h/%h want %h/%h", cyc, dataF.instr.pc, dataF.instr.raw_instr, exp_pc, mem_word(exp_pc));
        else passes++;
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
      chk_hold  = dataF.valid && stall && !redir;
      snap      = dataF;
      chk_flush = redir;
      if (redir) exp_pc = target;
      redirect_valid = redir;
      redirect_pc    = target;
      cycle();
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++; if (consumed < 40) $display("FAIL rand_progress: got %0d want >=40", consumed); else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; iresp = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_same();
    test_reset_mid();
`ifdef FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
